pupil_locator: RTL and testbench
================================

// Module: pupil_locator
// PURPOSE
//  Consumes the registered grayscale stream from the RGB-to-gray stage.
//  Binarizes each pixel against a threshold; the binary video feeds the VGA path.
//  Accumulates the coordinates of dark pixels over a frame.
//  At frame end, computes the pupil centroid with a sequential divider.
// PARAMETERS
//  H_ACTIVE    640  active pixels per line (x wraps at H_ACTIVE-1)
//  V_ACTIVE    480  active lines per frame (y saturates at V_ACTIVE-1)
//  MIN_PIXELS  64   minimum dark-pixel count for a valid result
// PORTS
//  iCLK         in   1   pixel clock
//  iRST         in   1   async reset, active low
//  iFVAL        in   1   frame valid, high for the whole active frame
//  iDVAL        in   1   pixel valid, aligned with iGRAY
//  iGRAY        in   10  grayscale pixel
//  iTHRESH      in   10  dark threshold
//  oDVAL        out  1   iDVAL delayed by 1 cycle
//  oBIN         out  10  10'h3FF if pixel dark, else 0 (1-cycle latency)
//  oPUPIL_X     out  11  centroid x, truncated
//  oPUPIL_Y     out  11  centroid y, truncated
//  oDARK_CNT    out  20  dark-pixel count of last evaluated frame
//  oPUPIL_VALID out  1   level; last evaluation had count >= MIN_PIXELS
//  oDONE        out  1   1-cycle pulse when outputs update
//  oBUSY        out  1   high in DIV_X/DIV_Y/DONE
// BEHAVIOUR
//  Reset (iRST=0, async): every output 0, counters/accumulators 0, FSM IDLE, divider aborted.
//  Pixel path: oDVAL<=iDVAL; oBIN<=(iDVAL && iGRAY<iTHRESH) ? 10'h3FF : 0.
//   - Equality is not dark.
//   - Runs in every FSM state, including while iFVAL is low.
//  Coordinates:
//   - x,y cleared on the cycle an iFVAL rising edge is sampled.
//   - Each iDVAL: x++; at H_ACTIVE-1, x->0 and y++ (y saturates).
//  Accumulate: in ACCUM, on each iDVAL with dark pixel: sum_x+=x, sum_y+=y, cnt++.
//   - cnt saturates at 2^20-1; sums are 32-bit.
//  FSM states and transitions:
//   - IDLE -> ACCUM on iFVAL rise; sums and count cleared.
//   - ACCUM -> DIV_X on iFVAL fall.
//   - ACCUM -> DONE on iFVAL fall if cnt<MIN_PIXELS (no divide).
//   - DIV_X: start divider with sum_x/cnt, wait for done (33 cycles).
//   - DIV_X -> DIV_Y: store quotient, start sum_y/cnt (33 cycles).
//   - DIV_Y -> DONE.
//   - DONE: pulse oDONE, load outputs, return to IDLE.
//  Outputs in DONE:
//   - Valid frame: X/Y = quotient[10:0], VALID=1.
//   - Below threshold: VALID=0, X/Y hold old values.
//   - oDARK_CNT always loaded.
//  Latency: oDONE exactly 68 cycles after the iFVAL fall is sampled (valid case); 1 cycle (invalid case).
//  Boundaries:
//   - iFVAL rise during DIV_X/DIV_Y/DONE: that frame is not accumulated; next rise is.
//   - iFVAL fall in the same cycle as the last iDVAL: that pixel is accumulated.
//   - Divide by zero cannot occur (MIN_PIXELS >= 1 enforced by elaboration check).
// CONFIGURATION
//  PUPIL_BBOX_EN defined:
//   - Adds outputs oBBOX_XMIN/XMAX/YMIN/YMAX (11b each).
//   - Min/max of dark-pixel coordinates, loaded in DONE.
//   - Reset values: MIN=0x7FF, MAX=0.
//  PUPIL_BBOX_EN undefined: these ports and registers are absent; all other behaviour is identical.
// STRUCTURE
//  pupil_pkg: FSM state enum (IDLE, ACCUM, DIV_X, DIV_Y, DONE);
//   COORD_W=11, ACC_W=32, CNT_W=20, PIX_W=10, WHITE=10'h3FF.
//  Sub-module pupil_divider:
//   - 32-bit unsigned restoring divider, 1 bit/cycle.
//   - Ports: iCLK, iRST, iSTART, iNUM, iDEN, oQUO, oDONE.
//   - oDONE pulses 33 cycles after iSTART.
// TESTING (H_ACTIVE=8, V_ACTIVE=8, MIN_PIXELS=4 unless noted)
//  1. iTHRESH=512, iGRAY=511 then 512 with iDVAL -> oBIN=0x3FF then 0, each 1 cycle later.
//  2. Dark 4x4 square, x 2..5, y 3..6 -> oDONE 68 cycles after iFVAL fall;
//     X=3, Y=4, CNT=16, VALID=1.
//  3. Next frame with only 3 dark pixels -> oDONE 1 cycle after fall;
//     VALID=0, CNT=3, X=3, Y=4 held.
//  4. iFVAL rises during DIV_X -> that frame is ignored;
//     following frame (square of test 2) -> X=3, Y=4.
//  5. iRST low mid DIV_Y -> all outputs 0, oBUSY=0;
//     next full frame of test 2 gives X=3, Y=4.
//  6. PUPIL_BBOX_EN, square of test 2 -> XMIN=2, XMAX=5, YMIN=3, YMAX=6.

Source files
------------

// File: rtl/pupil_pkg.sv
// ---------------------------------------------------------------------------
// pupil_pkg : shared widths, constants and FSM state encoding for pupil_locator
// Revision  : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package pupil_pkg;
  localparam int COORD_W = 11;
  localparam int ACC_W   = 32;
  localparam int CNT_W   = 20;
  localparam int PIX_W   = 10;
  localparam logic [PIX_W-1:0] WHITE = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

`default_nettype wire

// File: rtl/pupil_divider.sv
// ---------------------------------------------------------------------------
// pupil_divider : 32-bit unsigned restoring divider, one quotient bit per cycle
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pupil_divider
  import pupil_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iSTART,
  input  logic [ACC_W-1:0] iNUM,
  input  logic [ACC_W-1:0] iDEN,
  output logic [ACC_W-1:0] oQUO,
  output logic             oDONE
);
  localparam int STEP_W = $clog2(ACC_W);

  logic [ACC_W-1:0]  rem;
  logic [ACC_W-1:0]  den;
  logic [STEP_W-1:0] step;
  logic              run;
  logic [ACC_W:0]    shifted;
  logic              fits;

  // The quotient register doubles as the numerator shift register.
  assign shifted = {rem, oQUO[ACC_W-1]};
  assign fits    = shifted >= {1'b0, den};

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      rem   <= '0;
      den   <= '0;
      oQUO  <= '0;
      step  <= '0;
      run   <= 1'b0;
      oDONE <= 1'b0;
    end else begin
      oDONE <= 1'b0;
      if (iSTART) begin
        rem  <= '0;
        oQUO <= iNUM;
        den  <= iDEN;
        step <= '0;
        run  <= 1'b1;
      end else if (run) begin
        rem  <= fits ? ACC_W'(shifted - {1'b0, den}) : shifted[ACC_W-1:0];
        oQUO <= {oQUO[ACC_W-2:0], fits};
        step <= step + 1'b1;
        if (step == STEP_W'(ACC_W - 1)) begin
          run   <= 1'b0;
          oDONE <= 1'b1;
        end
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/pupil_locator.sv
// ---------------------------------------------------------------------------
// pupil_locator : binarizes gray video and computes the dark-pixel centroid
//                 per frame. Optional bounding box with PUPIL_BBOX_EN.
// Revision      : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module pupil_locator
  import pupil_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int MIN_PIXELS = 64
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic               iFVAL,
  input  logic               iDVAL,
  input  logic [PIX_W-1:0]   iGRAY,
  input  logic [PIX_W-1:0]   iTHRESH,
  output logic               oDVAL,
  output logic [PIX_W-1:0]   oBIN,
  output logic [COORD_W-1:0] oPUPIL_X,
  output logic [COORD_W-1:0] oPUPIL_Y,
  output logic [CNT_W-1:0]   oDARK_CNT,
  output logic               oPUPIL_VALID,
  output logic               oDONE,
  output logic               oBUSY
`ifdef PUPIL_BBOX_EN
  ,
  output logic [COORD_W-1:0] oBBOX_XMIN,
  output logic [COORD_W-1:0] oBBOX_XMAX,
  output logic [COORD_W-1:0] oBBOX_YMIN,
  output logic [COORD_W-1:0] oBBOX_YMAX
`endif
);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);
  localparam logic [CNT_W-1:0]   CNT_MIN = CNT_W'(MIN_PIXELS);

  generate
    if (MIN_PIXELS < 1) begin : g_minPixelsCheck
      $error("MIN_PIXELS must be at least 1");
    end
  endgenerate

  state_t             state;
  logic               fvalQ, rise, fall, isDark, accEn, startX;
  logic [COORD_W-1:0] x, y, quoX;
  logic [ACC_W-1:0]   sumX, sumY;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic               divStart, divDone, divQuoUnused;
  logic [ACC_W-1:0]   divNum, divDen, divQuo;
`ifdef PUPIL_BBOX_EN
  logic [COORD_W-1:0] xMin, xMax, yMin, yMax;
`endif

  assign rise    = iFVAL & ~fvalQ;
  assign fall    = ~iFVAL & fvalQ;
  assign isDark  = iGRAY < iTHRESH;
  assign accEn   = (state == ACCUM) && iDVAL && isDark;
  assign cntNext = (accEn && cnt != '1) ? cnt + 1'b1 : cnt;

  // Y division launches in the very cycle X finishes, keeping the chain at 66 cycles.
  assign divStart = startX | ((state == DIV_X) & divDone);
  assign divNum   = divDone ? sumY : sumX;
  assign divDen   = ACC_W'(cnt);
  assign divQuoUnused = &{1'b0, divQuo[ACC_W-1:COORD_W]};

  pupil_divider uDivider (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iSTART (divStart),
    .iNUM   (divNum),
    .iDEN   (divDen),
    .oQUO   (divQuo),
    .oDONE  (divDone)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      fvalQ <= 1'b0;
      oDVAL <= 1'b0;
      oBIN  <= '0;
      x     <= '0;
      y     <= '0;
    end else begin
      fvalQ <= iFVAL;
      oDVAL <= iDVAL;
      oBIN  <= (iDVAL && isDark) ? WHITE : '0;
      if (rise) begin
        x <= '0;
        y <= '0;
      end else if (iDVAL) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y != Y_LAST) y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state        <= IDLE;
      sumX         <= '0;
      sumY         <= '0;
      cnt          <= '0;
      quoX         <= '0;
      startX       <= 1'b0;
      oPUPIL_X     <= '0;
      oPUPIL_Y     <= '0;
      oDARK_CNT    <= '0;
      oPUPIL_VALID <= 1'b0;
      oDONE        <= 1'b0;
      oBUSY        <= 1'b0;
`ifdef PUPIL_BBOX_EN
      xMin <= '1;  xMax <= '0;  yMin <= '1;  yMax <= '0;
      oBBOX_XMIN <= '1;  oBBOX_XMAX <= '0;
      oBBOX_YMIN <= '1;  oBBOX_YMAX <= '0;
`endif
    end else begin
      startX <= 1'b0;
      oDONE  <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          state <= ACCUM;
          sumX  <= '0;
          sumY  <= '0;
          cnt   <= '0;
`ifdef PUPIL_BBOX_EN
          xMin <= '1;  xMax <= '0;  yMin <= '1;  yMax <= '0;
`endif
        end
        ACCUM: begin
          if (accEn) begin
            sumX <= sumX + ACC_W'(x);
            sumY <= sumY + ACC_W'(y);
            cnt  <= cntNext;
`ifdef PUPIL_BBOX_EN
            if (x < xMin) xMin <= x;
            if (x > xMax) xMax <= x;
            if (y < yMin) yMin <= y;
            if (y > yMax) yMax <= y;
`endif
          end
          if (fall) begin
            oBUSY <= 1'b1;
            if (cntNext >= CNT_MIN) begin
              state  <= DIV_X;
              startX <= 1'b1;
            end else begin
              state <= DONE;
            end
          end
        end
        DIV_X: if (divDone) begin
          quoX  <= divQuo[COORD_W-1:0];
          state <= DIV_Y;
        end
        DIV_Y: if (divDone) state <= DONE;
        DONE: begin
          state     <= IDLE;
          oDONE     <= 1'b1;
          oBUSY     <= 1'b0;
          oDARK_CNT <= cnt;
          if (cnt >= CNT_MIN) begin
            oPUPIL_X     <= quoX;
            oPUPIL_Y     <= divQuo[COORD_W-1:0];
            oPUPIL_VALID <= 1'b1;
          end else begin
            oPUPIL_VALID <= 1'b0;
          end
`ifdef PUPIL_BBOX_EN
          oBBOX_XMIN <= xMin;  oBBOX_XMAX <= xMax;
          oBBOX_YMIN <= yMin;  oBBOX_YMAX <= yMax;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_pupil_locator.sv
// ---------------------------------------------------------------------------
// tb_pupil_locator : directed self-checking bench for pupil_locator (8x8 frames)
// Revision         : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pupil_locator;
  logic        iCLK = 1'b0;
  logic        iRST = 1'b0;
  logic        iFVAL = 1'b0, iDVAL = 1'b0;
  logic [9:0]  iGRAY = '0, iTHRESH = 10'd512;
  logic        oDVAL, oPUPIL_VALID, oDONE, oBUSY;
  logic [9:0]  oBIN;
  logic [10:0] oPUPIL_X, oPUPIL_Y;
  logic [19:0] oDARK_CNT;
`ifdef PUPIL_BBOX_EN
  logic [10:0] oBBOX_XMIN, oBBOX_XMAX, oBBOX_YMIN, oBBOX_YMAX;
`endif
  int checks = 0;
  int fails  = 0;

  always #5 iCLK = ~iCLK;

  pupil_locator #(.H_ACTIVE(8), .V_ACTIVE(8), .MIN_PIXELS(4)) dut (
    .iCLK(iCLK), .iRST(iRST), .iFVAL(iFVAL), .iDVAL(iDVAL),
    .iGRAY(iGRAY), .iTHRESH(iTHRESH), .oDVAL(oDVAL), .oBIN(oBIN),
    .oPUPIL_X(oPUPIL_X), .oPUPIL_Y(oPUPIL_Y), .oDARK_CNT(oDARK_CNT),
    .oPUPIL_VALID(oPUPIL_VALID), .oDONE(oDONE), .oBUSY(oBUSY)
`ifdef PUPIL_BBOX_EN
    , .oBBOX_XMIN(oBBOX_XMIN), .oBBOX_XMAX(oBBOX_XMAX),
    .oBBOX_YMIN(oBBOX_YMIN), .oBBOX_YMAX(oBBOX_YMAX)
`endif
  );

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  // region 0: square x2..5,y3..6; 1: (0,0),(1,0),(7,7); 2: x6..7,y0..1
  function automatic bit darkAt(input int region, input int x, input int y);
    case (region)
      0: return (x >= 2 && x <= 5 && y >= 3 && y <= 6);
      1: return (y == 0 && x <= 1) || (x == 7 && y == 7);
      default: return (x >= 6 && y <= 1);
    endcase
  endfunction

  task automatic sendFrame(input int region, input bit fallWithLast);
    iFVAL = 1'b1; iDVAL = 1'b0;
    tick;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        iDVAL = 1'b1;
        iGRAY = darkAt(region, x, y) ? 10'd100 : 10'd900;
        if (fallWithLast && x == 7 && y == 7) iFVAL = 1'b0;
        tick;
      end
    end
    iDVAL = 1'b0;
    if (!fallWithLast) begin
      iFVAL = 1'b0;
      tick;
    end
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int i = 1; i <= 200; i++) begin
      tick;
      if (oDONE === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic checkResult(input string tag, input int lat, input int expLat,
                             input int ex, input int ey, input int ecnt, input bit evalid);
    checks++;
    if (lat !== expLat) begin fails++; $display("FAIL %s latency: got %0d expected %0d", tag, lat, expLat); end
    checks++;
    if (oPUPIL_X !== 11'(ex)) begin fails++; $display("FAIL %s x: got %0d expected %0d", tag, oPUPIL_X, ex); end
    checks++;
    if (oPUPIL_Y !== 11'(ey)) begin fails++; $display("FAIL %s y: got %0d expected %0d", tag, oPUPIL_Y, ey); end
    checks++;
    if (oDARK_CNT !== 20'(ecnt)) begin fails++; $display("FAIL %s cnt: got %0d expected %0d", tag, oDARK_CNT, ecnt); end
    checks++;
    if (oPUPIL_VALID !== evalid) begin fails++; $display("FAIL %s valid: got %b expected %b", tag, oPUPIL_VALID, evalid); end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({oDVAL, oBIN, oPUPIL_X, oPUPIL_Y, oDARK_CNT, oPUPIL_VALID, oDONE, oBUSY} !== '0) begin
      fails++; $display("FAIL reset_outputs: got x=%0d y=%0d cnt=%0d v=%b d=%b b=%b bin=%h expected all zero",
                        oPUPIL_X, oPUPIL_Y, oDARK_CNT, oPUPIL_VALID, oDONE, oBUSY, oBIN);
    end
`ifdef PUPIL_BBOX_EN
    checks++;
    if ({oBBOX_XMIN, oBBOX_XMAX, oBBOX_YMIN, oBBOX_YMAX} !== {11'h7FF, 11'h0, 11'h7FF, 11'h0}) begin
      fails++; $display("FAIL reset_bbox: got %h %h %h %h expected 7ff 0 7ff 0",
                        oBBOX_XMIN, oBBOX_XMAX, oBBOX_YMIN, oBBOX_YMAX);
    end
`endif
    tick;
    iRST = 1'b1;
    tick;
  endtask

  task automatic test_binarize;
    iTHRESH = 10'd512;
    iDVAL = 1'b1; iGRAY = 10'd511;
    tick;
    checks++;
    if (oBIN !== 10'h3FF) begin fails++; $display("FAIL bin_below: got %h expected 3ff", oBIN); end
    checks++;
    if (oDVAL !== 1'b1) begin fails++; $display("FAIL dval_delay: got %b expected 1", oDVAL); end
    iGRAY = 10'd512;
    tick;
    checks++;
    if (oBIN !== 10'h000) begin fails++; $display("FAIL bin_equal: got %h expected 000", oBIN); end
    iDVAL = 1'b0; iGRAY = 10'd5;
    tick;
    checks++;
    if ({oDVAL, oBIN} !== 11'h0) begin fails++; $display("FAIL bin_no_dval: got dval=%b bin=%h expected 0 000", oDVAL, oBIN); end
  endtask

  task automatic test_valid_frame;
    int lat;
    sendFrame(0, 1'b0);
    tick;
    checks++;
    if (oBUSY !== 1'b1) begin fails++; $display("FAIL busy_div: got %b expected 1", oBUSY); end
    waitDone(lat);
    checkResult("square", lat + 1, 68, 3, 4, 16, 1'b1);
    tick;
    checks++;
    if ({oDONE, oBUSY} !== 2'b00) begin fails++; $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", oDONE, oBUSY); end
`ifdef PUPIL_BBOX_EN
    checks++;
    if ({oBBOX_XMIN, oBBOX_XMAX, oBBOX_YMIN, oBBOX_YMAX} !== {11'd2, 11'd5, 11'd3, 11'd6}) begin
      fails++; $display("FAIL bbox_square: got %0d %0d %0d %0d expected 2 5 3 6",
                        oBBOX_XMIN, oBBOX_XMAX, oBBOX_YMIN, oBBOX_YMAX);
    end
`endif
  endtask

  task automatic test_below_min;
    int lat;
    sendFrame(1, 1'b1);
    waitDone(lat);
    checkResult("below_min", lat, 1, 3, 4, 3, 1'b0);
  endtask

  task automatic test_rise_while_busy;
    int lat;
    sendFrame(2, 1'b0);
    repeat (5) tick;
    iFVAL = 1'b1;
    tick;
    for (int x = 0; x < 8; x++) begin
      iDVAL = 1'b1; iGRAY = 10'd100;
      tick;
    end
    iDVAL = 1'b0; iFVAL = 1'b0;
    waitDone(lat);
    checkResult("corner_min_count", (lat > 0) ? 1 : 0, 1, 6, 0, 4, 1'b1);
    repeat (3) tick;
    sendFrame(0, 1'b0);
    waitDone(lat);
    checkResult("after_ignored", lat, 68, 3, 4, 16, 1'b1);
  endtask

  task automatic test_reset_in_div;
    int lat;
    sendFrame(0, 1'b0);
    repeat (45) tick;
    checks++;
    if (oBUSY !== 1'b1) begin fails++; $display("FAIL busy_div_y: got %b expected 1", oBUSY); end
    iRST = 1'b0;
    #2;
    checks++;
    if ({oPUPIL_X, oPUPIL_Y, oDARK_CNT, oPUPIL_VALID, oDONE, oBUSY, oDVAL, oBIN} !== '0) begin
      fails++; $display("FAIL async_reset: got x=%0d y=%0d cnt=%0d v=%b busy=%b expected all zero",
                        oPUPIL_X, oPUPIL_Y, oDARK_CNT, oPUPIL_VALID, oBUSY);
    end
    tick;
    iRST = 1'b1;
    repeat (80) tick;
    checks++;
    if ({oDONE, oBUSY} !== 2'b00) begin fails++; $display("FAIL aborted_divide: got done=%b busy=%b expected 0 0", oDONE, oBUSY); end
    sendFrame(0, 1'b0);
    waitDone(lat);
    checkResult("after_reset", lat, 68, 3, 4, 16, 1'b1);
  endtask

  initial begin
    test_reset;
    test_binarize;
    test_valid_frame;
    test_below_min;
    test_rise_while_busy;
    test_reset_in_div;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

`default_nettype wire
